// File: rtl/fetch_stream_buffer.sv
// fetch_stream_buffer: line fetcher feeding a circular byte buffer and a sliding decode window; define FETCH_STATS_EN for the statistics counters.
module fetch_stream_buffer #(
  parameter int BUS_W = 64,
  parameter int LINE_BYTES = 64,
  parameter int BUF_BYTES = 128,
  parameter int WIN_BYTES = 15,
  parameter int TAG_W = 13,
  parameter logic [TAG_W-1:0] FETCH_TAG = {1'b1, 4'b0001, 8'b0},
  localparam int CW = $clog2(WIN_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [63:0]            entry,
  output logic                   req_cyc,
  output logic [63:0]            req_addr,
  output logic [TAG_W-1:0]       req_tag,
  input  logic                   req_ack,
  input  logic                   resp_cyc,
  input  logic [BUS_W-1:0]       resp,
  output logic                   resp_ack,
  output logic [WIN_BYTES*8-1:0] win_bytes,
  output logic [CW-1:0]          win_count,
  output logic [63:0]            win_rip,
  input  logic                   consume,
  input  logic [CW-1:0]          consume_len,
  input  logic                   redirect,
  input  logic [63:0]            redirect_addr,
  output logic                   fetch_idle
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]            stat_lines,
  output logic [31:0]            stat_redirects,
  output logic [31:0]            stat_drained_beats
`endif
);
  localparam int BUS_BYTES = BUS_W / 8;
  localparam int BEATS = LINE_BYTES / BUS_BYTES;
  localparam int PW = $clog2(BUF_BYTES) + 1;
  localparam int AW = PW - 1;
  localparam int BW = $clog2(BUS_BYTES);
  localparam int LW = $clog2(LINE_BYTES);
  localparam int NW = (BEATS > 1) ? $clog2(BEATS) : 1;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, ACTIVE, DRAIN} state_t;
  state_t state;
  logic [7:0] mem [BUF_BYTES];
  logic [PW-1:0] wr_ptr, rd_ptr, occ;
  logic [63:0] line_addr, tgt_line;
  logic [NW-1:0] cnt, skip_beats;
  logic [BW-1:0] sub_skip;
  logic [CW-1:0] eff;
  logic first, drain_pend, beat, last, hit, wr_en, advance;
  assign req_tag = FETCH_TAG;
  assign resp_ack = resp_cyc;
  assign fetch_idle = (state == IDLE) && !req_cyc;
  // Occupancy, clamped consume and beat qualification; a redirect overrides any write or consume in its cycle.
  always_comb begin
    occ = wr_ptr - rd_ptr;
    win_count = (occ > PW'(WIN_BYTES)) ? CW'(WIN_BYTES) : CW'(occ);
    eff = (consume && !redirect) ? ((consume_len > win_count) ? win_count : consume_len) : '0;
    tgt_line = redirect_addr & ~64'(LINE_BYTES - 1);
    beat = resp_cyc && (state == WAIT || state == ACTIVE);
    last = cnt == NW'(BEATS - 1);
    hit = first && (cnt == skip_beats);
    wr_en = beat && !redirect && (!first || cnt >= skip_beats);
    advance = (state == REQ) && req_cyc && req_ack && !drain_pend && !redirect;
  end
  // Window reads wrap around the buffer end through the natural pointer overflow.
  always_comb begin
    win_bytes = '0;
    for (int i = 0; i < WIN_BYTES; i++) win_bytes[8*i +: 8] = mem[rd_ptr[AW-1:0] + AW'(i)];
  end
  // Beat-aligned write of a whole response beat into the byte buffer.
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int i = 0; i < BUS_BYTES; i++) mem[wr_ptr[AW-1:0] + AW'(i)] <= resp[8*i +: 8];
  end
  // Fetch FSM, pointers, target setup and request handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      req_cyc <= 1'b0;
      req_addr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      drain_pend <= 1'b0;
      first <= 1'b1;
      line_addr <= entry & ~64'(LINE_BYTES - 1);
      skip_beats <= entry[LW-1:BW];
      sub_skip <= entry[BW-1:0];
      win_rip <= entry;
    end else begin
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        first <= 1'b1;
        skip_beats <= redirect_addr[LW-1:BW];
        sub_skip <= redirect_addr[BW-1:0];
        win_rip <= redirect_addr;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PW'(BUS_BYTES);
        rd_ptr <= rd_ptr + PW'(eff) + ((wr_en && hit) ? PW'(sub_skip) : '0);
        win_rip <= win_rip + 64'(eff);
        if (beat && last) first <= 1'b0;
      end
      line_addr <= redirect ? tgt_line : advance ? line_addr + 64'(LINE_BYTES) : line_addr;
      if (resp_cyc && (state == WAIT || state == ACTIVE || state == DRAIN))
        cnt <= last ? '0 : cnt + 1'b1;
      case (state)
        IDLE: state <= (!redirect && occ <= PW'(BUF_BYTES - LINE_BYTES)) ? REQ : IDLE;
        REQ: begin
          if (!req_cyc) begin
            req_cyc <= 1'b1;
            req_addr <= redirect ? tgt_line : line_addr;
          end else if (req_ack) begin
            req_cyc <= 1'b0;
            drain_pend <= 1'b0;
            cnt <= '0;
            state <= (drain_pend || redirect) ? DRAIN : WAIT;
          end else if (redirect) drain_pend <= 1'b1;
        end
        WAIT, ACTIVE: state <= (resp_cyc && last) ? IDLE : redirect ? DRAIN : resp_cyc ? ACTIVE : state;
        DRAIN: state <= (resp_cyc && last) ? IDLE : DRAIN;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef FETCH_STATS_EN
  // Saturating counters of delivered lines, redirects and discarded beats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_lines <= '0;
      stat_redirects <= '0;
      stat_drained_beats <= '0;
    end else begin
      if (beat && last && !redirect && ~&stat_lines) stat_lines <= stat_lines + 1'b1;
      if (redirect && ~&stat_redirects) stat_redirects <= stat_redirects + 1'b1;
      if (resp_cyc && state == DRAIN && ~&stat_drained_beats) stat_drained_beats <= stat_drained_beats + 1'b1;
    end
  end
`endif
endmodule

// File: doc/fetch_stream_buffer.md
# fetch_stream_buffer

Parametrised instruction-fetch front end: requests cache lines from the system bus, gathers the response beats into a circular byte buffer and presents a sliding window of instruction bytes to the decoder. This generation adds byte-exact entry alignment, end-of-burst detection by beat count, branch redirect with in-flight burst draining, a clamped consume handshake and configurable widths and depths. It sits between the Sysbus request/response port and the decode stage of `Core`.

## Interface
- `BUS_W`, 64: response beat width in bits; `BUS_BYTES = BUS_W/8`, a power of two.
- `LINE_BYTES`, 64: bytes per line request, a power-of-two multiple of `BUS_BYTES`; `BEATS = LINE_BYTES/BUS_BYTES`.
- `BUF_BYTES`, 128: circular buffer size, a power-of-two multiple of `LINE_BYTES`, at least 2×.
- `WIN_BYTES`, 15: decode window width; must satisfy `WIN_BYTES <= BUF_BYTES`.
- `TAG_W`, 13 and `FETCH_TAG`, `{READ, MEMORY, 8'b0}`: request tag width and constant tag value.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `entry` in 64: start address, loaded while `reset_n` is low.
- `req_cyc` out 1: line request valid.
- `req_addr` out 64: line-aligned request address.
- `req_tag` out `TAG_W`: always `FETCH_TAG`.
- `req_ack` in 1: bus accepted the request.
- `resp_cyc` in 1: response beat valid.
- `resp` in `BUS_W`: beat data; byte 0 is bits [7:0].
- `resp_ack` out 1: equals `resp_cyc`, combinationally.
- `win_bytes` out `WIN_BYTES*8`: window; byte *i* is bits [8i+7:8i].
- `win_count` out clog2(`WIN_BYTES`+1): number of valid window bytes, `min(occupancy, WIN_BYTES)`.
- `win_rip` out 64: address of window byte 0.
- `consume` in 1 and `consume_len` in clog2(`WIN_BYTES`+1): decoder retires bytes.
- `redirect` in 1 and `redirect_addr` in 64: restart fetch at a new address.
- `fetch_idle` out 1: high when the state is IDLE and `req_cyc` is low.

## Operation
- Pointers:
  - `wr_ptr` and `rd_ptr` carry clog2(`BUF_BYTES`)+1 bits each, including a wrap bit.
  - occupancy = `wr_ptr - rd_ptr`.
  - `wr_ptr` always advances in `BUS_BYTES` steps. All beat writes are beat-aligned.
- Target setup, on reset or redirect to address A:
  - `line_addr = A & ~(LINE_BYTES-1)`
  - `skip_beats = A[log2 LINE_BYTES-1 : log2 BUS_BYTES]`
  - `sub_skip = A mod BUS_BYTES`
  - `win_rip = A`
  - both pointers are set to 0.
- First-line beat handling:
  - Beats with index below `skip_beats` are dropped.
  - The target beat is written; in the same cycle `rd_ptr` advances by `sub_skip`.
  - All later beats are written.
- State machine:
  - **IDLE → REQ**: no pending redirect and occupancy ≤ `BUF_BYTES - LINE_BYTES`. `req_cyc` rises the following cycle.
  - **REQ**: `req_cyc` is held, with `req_addr` and `req_tag` stable, until `req_ack` is sampled high. Then go to WAIT and advance `line_addr` by `LINE_BYTES`.
  - **WAIT → ACTIVE**: on the first `resp_cyc`. That beat counts as beat 0.
  - **ACTIVE**: a beat counter increments on each `resp_cyc`. After beat `BEATS-1`, go to IDLE. Gaps in `resp_cyc` are tolerated.
  - **DRAIN**: counts and discards the beats of the in-flight line, writing nothing. After beat `BEATS-1`, go to IDLE.
- Redirect handling:
  - Redirect in IDLE: apply the target immediately.
  - Redirect in REQ: `req_cyc` stays high until `req_ack`, then the state goes to DRAIN.
  - Redirect in WAIT or ACTIVE: go to DRAIN. The new target is applied at once, so the buffer empties and `win_rip = redirect_addr`.
  - The next request uses the new `line_addr`.
  - A second redirect during DRAIN overwrites the target. No extra drain is started.
- Consume:
  - `eff = min(consume_len, win_count)`.
  - `rd_ptr += eff` and `win_rip += eff`.
  - `consume` with `consume_len = 0` is a no-op.
- Simultaneous events:
  - Redirect beats consume in the same cycle; the consume is ignored.
  - A beat write and a consume in the same cycle both take effect.
- Window: `win_bytes[i] = buf[(rd_ptr+i) mod BUF_BYTES]`, read combinationally and wrapping across the buffer end. Bytes at or above `win_count` are don't-care.

## Timing
- Reset (asynchronous, `reset_n` low):
  - state IDLE, counters 0
  - `req_cyc` 0, `req_addr` 0
  - `win_count` 0, `win_rip = entry`
  - `fetch_idle` 1
  - buffer contents are unspecified.
- Reset asserted mid-burst abandons the burst immediately. Beats that arrive after reset are not tracked; the bus is reset together with this block.
- `req_cyc` first rises on the second rising edge after `reset_n` deasserts.
- Beat-to-window latency is 1 cycle: a beat sampled at edge N is visible in `win_bytes`/`win_count` after edge N.
- Consume takes effect at the next edge.
- Redirect gives `win_count = 0` after the next edge.

## Configuration
- `FETCH_STATS_EN`:
  - **Defined**: adds outputs `stat_lines` (32), `stat_redirects` (32) and `stat_drained_beats` (32). They are reset to 0 and saturate at all-ones. `stat_lines` counts completed non-drained lines.
  - **Undefined**: the ports and counters are absent; functional behaviour is identical.

## Test plan
- Entry at a line boundary: `entry=0x1000`; beat k = bytes 8k..8k+7 with values 0x00..0x3F.
  - `req_addr` = 0x1000.
  - After beat 7: `win_count` = 15, `win_bytes[0]` = 0x00, `win_rip` = 0x1000.
  - The second request is to 0x1040.
- Unaligned entry: `entry=0x100D`.
  - Beat 0 is dropped.
  - `win_bytes[0]` = 0x0D, `win_rip` = 0x100D.
  - Occupancy after the line is 51.
- Backpressure: no consume after two lines (occupancy 128).
  - No third request is issued.
  - Consume 15,15,15,15,4 (64 bytes): `req_cyc` rises with `req_addr` = 0x1080.
- Redirect to 0x2000 at beat 3 of a burst.
  - Beats 4–7 are discarded: `stat_drained_beats` = 4, and the window does not change.
  - `win_count` = 0, next `req_addr` = 0x2000.
- Wrap-around:
  - After `rd_ptr` reaches 120, the window shows buffer bytes 120..127 then 0..6, contiguous in address.
  - `consume_len` = 15 when `win_count` = 9 advances `win_rip` by 9.
- Redirect and consume in the same cycle:
  - `win_rip` = `redirect_addr`; the consume is ignored.
  - Reset asserted mid-burst gives `req_cyc` 0 and `win_count` 0 asynchronously.
